// File: rtl/exe_mem_pkg.sv
// Shared definitions for the EXE->MEM skid stage: state encoding, default widths,
// the beat layout and a saturating counter helper.
package exe_mem_pkg;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_RN_W   = 5;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] alu;
      logic [DEF_DATA_W-1:0] b;
      logic [DEF_RN_W-1:0]   rn;
      logic                  wreg;
      logic                  m2reg;
      logic                  wmem;
   } beat_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
      logic [31:0] nxt;
      if (en && (cnt != 32'hFFFF_FFFF)) begin
         nxt = cnt + 32'd1;
      end else begin
         nxt = cnt;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/exe_mem_slot.sv
// One beat-wide storage register with load enable and asynchronous clear;
// the skid stage uses two of these (main and skid entries).
module exe_mem_slot
   import exe_mem_pkg::*;
#(
   parameter int W = DEF_DATA_W
) (
   input  logic         clk,
   input  logic         clrn,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Beat storage: cleared on reset, loaded only when the stage commits a transfer.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         q <= {W{1'b0}};
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/exe_mem_skid_stage.sv
// EXE->MEM pipeline boundary with valid/ready handshake, two-entry skid buffer and flush.
// Optional performance counters are enabled with `define EXE_MEM_PERF_EN.
module exe_mem_skid_stage
   import exe_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int RN_W   = DEF_RN_W
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              exe_valid,
   output logic              exe_ready,
   input  logic [DATA_W-1:0] exe_alu,
   input  logic [DATA_W-1:0] exe_b,
   input  logic [RN_W-1:0]   exe_rn,
   input  logic              exe_wreg,
   input  logic              exe_m2reg,
   input  logic              exe_wmem,
   input  logic              flush,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] mem_alu,
   output logic [DATA_W-1:0] mem_b,
   output logic [RN_W-1:0]   mem_rn,
   output logic              mem_wreg,
   output logic              mem_m2reg,
   output logic              mem_wmem
`ifdef EXE_MEM_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   localparam int W = 2 * DATA_W + RN_W + 3;

   logic [1:0]   state_r;
   logic [1:0]   state_nxt_s;
   logic         accept_s;
   logic         drain_s;
   logic         load_main_s;
   logic         load_skid_s;
   logic         main_from_skid_s;
   logic [W-1:0] in_beat_s;
   logic [W-1:0] main_d_s;
   logic [W-1:0] main_q_s;
   logic [W-1:0] skid_q_s;
   logic         main_wreg_s;
   logic         main_wmem_s;

   // Handshake flags come from the state register only, so stall never sees mem_ready.
   assign exe_ready = (state_r != FULL);
   assign mem_valid = (state_r != EMPTY);
   assign accept_s  = exe_valid & exe_ready;
   assign drain_s   = mem_valid & mem_ready;

   assign in_beat_s = {exe_alu, exe_b, exe_rn, exe_wreg, exe_m2reg, exe_wmem};
   assign main_d_s  = main_from_skid_s ? skid_q_s : in_beat_s;

   // Next-state and load-enable decode; flush empties the stage and drops any accept.
   always_comb begin
      state_nxt_s      = state_r;
      load_main_s      = 1'b0;
      load_skid_s      = 1'b0;
      main_from_skid_s = 1'b0;
      if (flush) begin
         state_nxt_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  state_nxt_s = ONE;
                  load_main_s = 1'b1;
               end else begin
                  state_nxt_s = EMPTY;
               end
            end
            ONE: begin
               if (accept_s && drain_s) begin
                  state_nxt_s = ONE;
                  load_main_s = 1'b1;
               end else if (accept_s) begin
                  state_nxt_s = FULL;
                  load_skid_s = 1'b1;
               end else if (drain_s) begin
                  state_nxt_s = EMPTY;
               end else begin
                  state_nxt_s = ONE;
               end
            end
            FULL: begin
               if (drain_s) begin
                  state_nxt_s      = ONE;
                  load_main_s      = 1'b1;
                  main_from_skid_s = 1'b1;
               end else begin
                  state_nxt_s = FULL;
               end
            end
            default: begin
               state_nxt_s = EMPTY;
            end
         endcase
      end
   end

   // Occupancy state register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   exe_mem_slot #(.W(W)) u_main (
      .clk  (clk),
      .clrn (clrn),
      .load (load_main_s),
      .d    (main_d_s),
      .q    (main_q_s)
   );

   exe_mem_slot #(.W(W)) u_skid (
      .clk  (clk),
      .clrn (clrn),
      .load (load_skid_s),
      .d    (in_beat_s),
      .q    (skid_q_s)
   );

   assign {mem_alu, mem_b, mem_rn, main_wreg_s, mem_m2reg, main_wmem_s} = main_q_s;

   // Write enables are qualified so a stale head can never update the register file or memory.
   assign mem_wreg = main_wreg_s & mem_valid;
   assign mem_wmem = main_wmem_s & mem_valid;

`ifdef EXE_MEM_PERF_EN
   // Saturating stall and flush-of-live-data counters.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         perf_stall_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         perf_stall_cnt <= sat_inc(perf_stall_cnt, mem_valid & ~mem_ready);
         perf_flush_cnt <= sat_inc(perf_flush_cnt, flush & (state_r != EMPTY));
      end
   end
`endif

endmodule
